// File: rtl/bus_master_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bus_master_port : single-transaction CPU-to-bus initiator (optional BUS_TIMEOUT_EN watchdog)
// Revision 1.0
// ============================================================================
module bus_master_port #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_busy,
    output logic        cpu_err,
    output logic        request,
    output logic [31:0] address,
    output logic        r_w,
    inout  wire  [31:0] data,
    input  logic        ready_in
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] wdata_q;
    logic [31:0] address_nx, wdata_nx, rdata_nx;
    logic        request_nx, r_w_nx, done_nx, busy_nx, err_nx;
    logic        ready_hit;
    logic        tmo_hit;

    // A floating or unknown ready line must never complete a transaction.
    assign ready_hit = (ready_in === 1'b1);

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nx;
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    wire unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
    assign tmo_hit = 1'b0;
`endif

    assign data = (state == ST_WAIT && r_w) ? wdata_q : 32'bz;

    always_comb begin
        state_nx   = state;
        request_nx = request;
        address_nx = address;
        r_w_nx     = r_w;
        wdata_nx   = wdata_q;
        rdata_nx   = cpu_rdata;
        done_nx    = cpu_done;
        busy_nx    = cpu_busy;
        err_nx     = cpu_err;
`ifdef BUS_TIMEOUT_EN
        tmo_cnt_nx = tmo_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    address_nx = cpu_addr;
                    r_w_nx     = cpu_we;
                    wdata_nx   = cpu_wdata;
                    request_nx = 1'b1;
                    busy_nx    = 1'b1;
                    state_nx   = ST_WAIT;
`ifdef BUS_TIMEOUT_EN
                    tmo_cnt_nx = '0;
`endif
                end
            end
            ST_WAIT: begin
                // Ready has priority over a coincident timeout.
                if (ready_hit) begin
                    if (!r_w) begin
                        rdata_nx = data;
                    end
                    request_nx = 1'b0;
                    done_nx    = 1'b1;
                    err_nx     = 1'b0;
                    state_nx   = ST_DONE;
                end else if (tmo_hit) begin
                    request_nx = 1'b0;
                    done_nx    = 1'b1;
                    err_nx     = 1'b1;
                    rdata_nx   = 32'h0;
                    state_nx   = ST_DONE;
                end else begin
`ifdef BUS_TIMEOUT_EN
                    tmo_cnt_nx = tmo_cnt + 1'b1;
`endif
                end
            end
            ST_DONE: begin
                // Always passes through IDLE so the slave sees request low.
                done_nx  = 1'b0;
                err_nx   = 1'b0;
                busy_nx  = 1'b0;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            request   <= 1'b0;
            address   <= 32'h0;
            r_w       <= 1'b0;
            wdata_q   <= 32'h0;
            cpu_rdata <= 32'h0;
            cpu_done  <= 1'b0;
            cpu_busy  <= 1'b0;
            cpu_err   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            state     <= state_nx;
            request   <= request_nx;
            address   <= address_nx;
            r_w       <= r_w_nx;
            wdata_q   <= wdata_nx;
            cpu_rdata <= rdata_nx;
            cpu_done  <= done_nx;
            cpu_busy  <= busy_nx;
            cpu_err   <= err_nx;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt   <= tmo_cnt_nx;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_master_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_bus_master_port : directed bench with a 4-stage slave model on the bus
// Revision 1.0
// ============================================================================
module tb_bus_master_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_busy, cpu_err;
    logic        request, r_w;
    logic [31:0] address;
    wire  [31:0] data;
    wire         ready_in;

    int checks = 0;
    int errors = 0;

    // Slave model: accepts one edge after request, ready high for one cycle 3 edges later.
    logic [31:0] mem [0:63];
    logic [2:0]  s_cnt;
    logic        s_ready, s_drive, s_wait_low;
    logic [31:0] s_rdata;

    assign data     = s_drive ? s_rdata : 32'bz;
    assign ready_in = s_ready;

    bus_master_port #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy), .cpu_err(cpu_err),
        .request(request), .address(address), .r_w(r_w), .data(data), .ready_in(ready_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt      <= 3'd0;
            s_ready    <= 1'b0;
            s_drive    <= 1'b0;
            s_wait_low <= 1'b0;
            s_rdata    <= 32'h0;
        end else if (s_ready) begin
            s_ready    <= 1'b0;
            s_drive    <= 1'b0;
            s_cnt      <= 3'd0;
            s_wait_low <= 1'b1;
            if (r_w) mem[address[5:0]] <= data;
        end else if (s_wait_low) begin
            if (!request) s_wait_low <= 1'b0;
        end else if (request && address < 32'd64) begin
            if (s_cnt == 3'd3) begin
                s_ready <= 1'b1;
                s_drive <= !r_w;
                s_rdata <= mem[address[5:0]];
            end
            s_cnt <= s_cnt + 3'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one transaction from IDLE; returns after the cpu_done cycle (or the limit).
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] forbid, input int limit,
                       output int lat, output logic [31:0] rd, output logic er,
                       output logic drive_ok, output logic hold_ok);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        lat = 0; drive_ok = 1'b1; hold_ok = 1'b1;
        while (cpu_done !== 1'b1 && lat < limit) begin
            if (we) drive_ok &= (data === wd);
            else    drive_ok &= (data !== forbid);
            hold_ok &= (request === 1'b1 && address === a && r_w === we && cpu_busy === 1'b1);
            @(posedge clk); #1;
            lat++;
        end
        rd = cpu_rdata;
        er = cpu_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int          lat, ndone, accepts, gap;
    logic [31:0] rd;
    logic [31:0] rdb [0:1];
    logic        er, dok, hok, aok, prev;

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1] = 32'h11111111; mem[2] = 32'h22222222;
        mem[3] = 32'h12345678; mem[5] = 32'h55555555;

        // Reset state
        repeat (2) @(posedge clk); #1;
        check("rst_request", {31'h0, request}, 32'd0);
        check("rst_address", address, 32'h0);
        check("rst_r_w", {31'h0, r_w}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_done", {31'h0, cpu_done}, 32'd0);
        check("rst_busy", {31'h0, cpu_busy}, 32'd0);
        check("rst_err", {31'h0, cpu_err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Write to second slave
        txn(1'b1, 32'h21, 32'hCAFEF00D, 32'h0, 50, lat, rd, er, dok, hok);
        check("wr_latency", lat, 32'd5);
        check("wr_data_driven", {31'h0, dok}, 32'd1);
        check("wr_hold", {31'h0, hok}, 32'd1);
        check("wr_done_req_low", {31'h0, request}, 32'd0);
        check("wr_released", {31'h0, data !== 32'hCAFEF00D}, 32'd1);
        check("wr_err", {31'h0, er}, 32'd0);
        @(posedge clk); #1;
        check("wr_done_pulse", {31'h0, cpu_done}, 32'd0);
        check("wr_busy_clear", {31'h0, cpu_busy}, 32'd0);
        check("wr_mem", mem[6'h21], 32'hCAFEF00D);

        // Read addr 3; master must not drive the bus
        txn(1'b0, 32'h3, 32'h0, 32'hCAFEF00D, 50, lat, rd, er, dok, hok);
        check("rd_latency", lat, 32'd5);
        check("rd_no_drive", {31'h0, dok}, 32'd1);
        check("rd_hold", {31'h0, hok}, 32'd1);
        check("rd_data", rd, 32'h12345678);
        check("rd_err", {31'h0, er}, 32'd0);
        @(posedge clk); #1;
        check("rd_done_pulse", {31'h0, cpu_done}, 32'd0);
        check("rd_rdata_hold", cpu_rdata, 32'h12345678);

        // Read back the write
        txn(1'b0, 32'h21, 32'h0, 32'h0, 50, lat, rd, er, dok, hok);
        check("rb_data", rd, 32'hCAFEF00D);
        @(posedge clk); #1;

        // Request while busy is ignored
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3;
        ndone = 0; aok = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (i == 0) cpu_req = 1'b0;
            if (i == 1) begin cpu_req = 1'b1; cpu_addr = 32'h5; end
            if (i == 2) cpu_req = 1'b0;
            if (request === 1'b1) aok &= (address === 32'h3);
            if (cpu_done === 1'b1) begin ndone++; rd = cpu_rdata; end
        end
        check("busy_done_count", ndone, 32'd1);
        check("busy_addr_stable", {31'h0, aok}, 32'd1);
        check("busy_addr_final", address, 32'h3);
        check("busy_rdata", rd, 32'h12345678);

        // Back-to-back with cpu_req held high
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1;
        accepts = 0; ndone = 0; gap = 0; prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (request === 1'b1 && !prev) begin
                accepts++;
                if (accepts == 1) cpu_addr = 32'h2;
                else cpu_req = 1'b0;
            end
            prev = request;
            if (cpu_done === 1'b1) begin
                if (ndone < 2) rdb[ndone] = cpu_rdata;
                ndone++;
            end
            if (accepts == 1 && ndone == 1 && request === 1'b0) gap++;
        end
        check("b2b_accepts", accepts, 32'd2);
        check("b2b_dones", ndone, 32'd2);
        check("b2b_rdata0", rdb[0], 32'h11111111);
        check("b2b_rdata1", rdb[1], 32'h22222222);
        check("b2b_gap", gap, 32'd2);

        // Reset two cycles into a write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h22; cpu_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mrst_request", {31'h0, request}, 32'd0);
        check("mrst_address", address, 32'h0);
        check("mrst_r_w", {31'h0, r_w}, 32'd0);
        check("mrst_busy", {31'h0, cpu_busy}, 32'd0);
        check("mrst_released", {31'h0, data !== 32'hDEADBEEF}, 32'd1);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (cpu_done === 1'b1) ndone++;
        end
        check("mrst_no_done", ndone, 32'd0);
        check("mrst_mem_untouched", mem[6'h22], 32'h0);
        txn(1'b0, 32'h3, 32'h0, 32'hDEADBEEF, 50, lat, rd, er, dok, hok);
        check("mrst_rd_latency", lat, 32'd5);
        check("mrst_rd_data", rd, 32'h12345678);
        @(posedge clk); #1;

        // Unmapped address
`ifdef BUS_TIMEOUT_EN
        txn(1'b0, 32'h100, 32'h0, 32'h0, 40, lat, rd, er, dok, hok);
        check("tmo_latency", lat, 32'd16);
        check("tmo_err", {31'h0, er}, 32'd1);
        check("tmo_rdata", rd, 32'h0);
        check("tmo_req_low", {31'h0, request}, 32'd0);
        @(posedge clk); #1;
        check("tmo_err_clear", {31'h0, cpu_err}, 32'd0);
`else
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        aok = 1'b1; ndone = 0;
        for (int i = 0; i < 100; i++) begin
            aok &= (request === 1'b1);
            if (cpu_done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        check("nomap_req_held", {31'h0, aok}, 32'd1);
        check("nomap_no_done", ndone, 32'd0);
        check("nomap_err", {31'h0, cpu_err}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("nomap_rst_request", {31'h0, request}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Single-transaction bus initiator. It converts a CPU-side load/store request into the system bus handshake (request/address/r_w/data, ready), waits for the addressed slave's one-cycle ready pulse and returns read data or completion to the CPU.
- Sits between the CPU memory stage and the shared tristate bus, opposite the memory/peripheral slaves.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT before abort; used only when BUS_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  start-transaction strobe; sampled only in IDLE
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  32  transaction address
- cpu_wdata  input  32  write data
- cpu_rdata  output  32  read data; valid while cpu_done=1
- cpu_done  output  1  one-cycle completion pulse
- cpu_busy  output  1  high from acceptance until the cycle after cpu_done
- cpu_err  output  1  transaction aborted (timeout); qualified by cpu_done
- request  output  1  bus request
- address  output  32  bus address
- r_w  output  1  bus direction; 1 = write
- data  inout  32  tristate bus data
- ready_in  input  1  bus ready line (tri0 pulldown; Z reads as 0)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; request=0, address=0, r_w=0, cpu_rdata=0, cpu_done=0, cpu_busy=0, cpu_err=0, timeout counter=0; data released to Z immediately. Reset mid-transaction abandons the transaction with no cpu_done.
- All bus and CPU outputs are registered. No combinational path from cpu_* inputs to bus pins.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On cpu_req=1, latch cpu_addr, cpu_we and cpu_wdata into address, r_w and the write-data register.
  - Set request=1 and cpu_busy=1, then go to WAIT.
  - When cpu_req=0, stay in IDLE.
- WAIT:
  - request, address, r_w and the write data are held stable for every cycle of WAIT.
  - data is driven with the write-data register only when in WAIT and r_w=1. Otherwise data is Z; a read never drives data.
  - Only ready_in===1 counts as ready. Z/X/0 mean not ready.
  - On ready_in=1: capture data into cpu_rdata (reads only; writes leave cpu_rdata unchanged), set request=0, release data, set cpu_done=1, then go to DONE.
- DONE:
  - cpu_done returns to 0, cpu_err returns to 0 and cpu_busy returns to 0. Next state is IDLE.
  - cpu_req is ignored in DONE. This guarantees at least one request-low cycle so the slave returns to its idle state before the next transaction.
- cpu_req asserted in WAIT or DONE is ignored; it is not queued.
- Timing against a 4-stage slave:
  - cpu_req is sampled at edge 0 and request rises.
  - The slave accepts at edge 1 and drives ready between edges 4 and 5.
  - The master samples ready at edge 5, and cpu_done is high between edges 5 and 6.
  - Minimum issue-to-issue spacing is 7 cycles.
- Simultaneous ready_in=1 and timeout expiry in the same cycle: ready wins (normal completion, cpu_err=0).

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle without ready.
  - When the count reaches TIMEOUT_CYCLES: set request=0, release data, set cpu_done=1, cpu_err=1 and cpu_rdata=32'h0, then go to DONE. Covers unmapped addresses.
- Not defined: no counter; cpu_err is tied 0; WAIT persists until ready_in=1.

Test Plan:
- Read: slave preloaded mem[3]=32'h12345678; cpu_req with cpu_we=0, cpu_addr=3 -> request high for 5 cycles, data never driven by the master, cpu_done for exactly 1 cycle with cpu_rdata=32'h12345678 and cpu_err=0.
- Write then read back: write 32'hCAFEF00D to 32'h21 (second slave) -> data driven with 32'hCAFEF00D throughout WAIT with r_w=1, then cpu_done. Read 32'h21 -> cpu_rdata=32'hCAFEF00D.
- Busy rejection: pulse cpu_req with addr 5 while in WAIT for addr 3 -> only one bus transaction occurs (address stays 3); exactly one cpu_done.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): read address 32'h100 (no slave, ready_in floats Z) -> cpu_done with cpu_err=1 and cpu_rdata=0 after 16 WAIT cycles, request low afterward. Without the macro, request stays high for at least 100 cycles.
- Reset mid-operation: assert rst_n=0 two cycles into a write -> request, address, r_w and cpu_busy go to 0 and data goes to Z without waiting for a clock edge; no cpu_done is ever produced. After release, a read of addr 3 completes normally.
- Back-to-back: hold cpu_req=1 continuously with addrs 1, 2 -> request low for at least 1 cycle between transactions; both complete with the correct data.
